// File: rtl/pipelined_ripple_adder.sv
// Ripple adder split into STAGES registered chunks with a valid/ready pipeline.
// Each stage adds one CHUNK of the operands and carries the unused upper chunks forward.
module pipelined_ripple_adder #(
  parameter int DATA_WIDTH = 16,
  parameter int STAGES     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  ci,
  input  logic                  sub,
  input  logic                  in_vld,
  output logic                  in_rd,
  output logic [DATA_WIDTH-1:0] s,
  output logic                  co,
  output logic                  out_vld,
  input  logic                  out_rd
);

  localparam int CHUNK = DATA_WIDTH / STAGES;

  if (STAGES < 1 || STAGES > DATA_WIDTH || (DATA_WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipelined_ripple_adder: STAGES must divide DATA_WIDTH");
  end

  logic [DATA_WIDTH-1:0] b_eff;
  logic                  c_eff;
  logic [STAGES-1:0]     vld;
  logic [STAGES-1:0]     load;

  assign b_eff = sub ? ~b : b;
  assign c_eff = sub ? 1'b1 : ci;

  // A stage may load whenever any stage at or after it has a hole, or the
  // consumer is draining the last stage; avoids a self-referencing chain.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      load[k] = out_rd;
      for (int j = k; j < STAGES; j++) begin
        if (!vld[j]) load[k] = 1'b1;
      end
    end
  end

  assign in_rd = load[0];

  for (genvar k = 0; k < STAGES; k++) begin : stg
    logic [CHUNK-1:0]         op_a;
    logic [CHUNK-1:0]         op_b;
    logic                     c_in;
    logic                     v_in;
    logic [CHUNK:0]           part;
    logic [(k+1)*CHUNK-1:0]   sum_d;
    logic [(k+1)*CHUNK-1:0]   sum_q;
    logic                     c_q;
    logic                     v_q;

    assign part = {1'b0, op_a} + {1'b0, op_b} + {{CHUNK{1'b0}}, c_in};

    if (k == 0) begin : g_src
      assign op_a  = a[CHUNK-1:0];
      assign op_b  = b_eff[CHUNK-1:0];
      assign c_in  = c_eff;
      assign v_in  = in_vld;
      assign sum_d = part[CHUNK-1:0];
    end else begin : g_src
      assign op_a  = stg[k-1].g_rem.a_q[CHUNK-1:0];
      assign op_b  = stg[k-1].g_rem.b_q[CHUNK-1:0];
      assign c_in  = stg[k-1].c_q;
      assign v_in  = stg[k-1].v_q;
      assign sum_d = {part[CHUNK-1:0], stg[k-1].sum_q};
    end

    // Bubbles advance the valid bit only, so held results never get overwritten.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        sum_q <= '0;
      end else if (load[k]) begin
        v_q <= v_in;
        if (v_in) begin
          c_q   <= part[CHUNK];
          sum_q <= sum_d;
        end
      end
    end

    assign vld[k] = v_q;

    if (k < STAGES-1) begin : g_rem
      localparam int REM = DATA_WIDTH - (k+1)*CHUNK;
      logic [REM-1:0] a_d, b_d, a_q, b_q;

      if (k == 0) begin : g_d
        assign a_d = a[DATA_WIDTH-1:CHUNK];
        assign b_d = b_eff[DATA_WIDTH-1:CHUNK];
      end else begin : g_d
        assign a_d = stg[k-1].g_rem.a_q[DATA_WIDTH-k*CHUNK-1:CHUNK];
        assign b_d = stg[k-1].g_rem.b_q[DATA_WIDTH-k*CHUNK-1:CHUNK];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (load[k] && v_in) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end
  end

  assign s       = stg[STAGES-1].sum_q;
  assign co      = stg[STAGES-1].c_q;
  assign out_vld = vld[STAGES-1];

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Bench for pipelined_ripple_adder: directed corner cases plus random traffic
// checked against an arithmetic reference model and an in-order scoreboard.
module tb_pipelined_ripple_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        ci = 1'b0, sub = 1'b0, in_vld = 1'b0, out_rd = 1'b0;
  logic        in_rd, co, out_vld;
  logic [15:0] s;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_out_cyc = -10;
  int run = 0;
  int out_cnt = 0;
  logic [16:0] exp_q[$];

  pipelined_ripple_adder #(.DATA_WIDTH(16), .STAGES(4)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .ci(ci), .sub(sub),
    .in_vld(in_vld), .in_rd(in_rd), .s(s), .co(co),
    .out_vld(out_vld), .out_rd(out_rd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] model(input logic [15:0] x, input logic [15:0] y,
                                         input logic c, input logic sb);
    if (sb) return {(x >= y), 16'(x - y)};
    return {1'b0, x} + {1'b0, y} + 17'(c);
  endfunction

  // Transfers are judged at the negedge, i.e. what the next rising edge will see.
  always @(negedge clk) begin
    cyc++;
    if (out_vld && out_rd) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 32'(out_vld), 32'(0));
      end else begin
        check("result", 32'({co, s}), 32'(exp_q.pop_front()));
      end
      out_cnt++;
      run = (cyc == last_out_cyc + 1) ? run + 1 : 1;
      last_out_cyc = cyc;
    end
    if (in_vld && in_rd) exp_q.push_back(model(a, b, ci, sub));
  end

  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic c, input logic sb);
    int n = 0;
    a = x; b = y; ci = c; sub = sb; in_vld = 1'b1;
    @(negedge clk);
    while (!in_rd && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_rd) check("send_timeout", 32'(in_rd), 32'(1));
    @(posedge clk);
    #1 in_vld = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 1;
    while (!out_vld && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1 check("drain_empty", 32'(exp_q.size()), 32'(0));
  endtask

  task automatic directed(input string tag, input logic [15:0] x, input logic [15:0] y,
                          input logic c, input logic sb, input logic [16:0] want);
    int lat;
    out_rd = 1'b1;
    send(x, y, c, sb);
    wait_result(lat);
    check({tag, "_lat"}, 32'(lat), 32'(4));
    check({tag, "_val"}, 32'({co, s}), 32'(want));
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, base, lat, n;
    logic [16:0] snap;
    logic have;

    #3;
    check("rst_in_rd", 32'(in_rd), 32'(1));
    check("rst_out_vld", 32'(out_vld), 32'(0));
    check("rst_s_co", 32'({co, s}), 32'(0));
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;

    directed("basic_add", 16'h1234, 16'h4321, 1'b1, 1'b0, 17'h0_5556);
    directed("carry_all", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 17'h1_0000);
    directed("carry_max", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 17'h1_FFFF);
    directed("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 17'h0_FFFE);
    directed("sub_ok", 16'h0007, 16'h0005, 1'b1, 1'b1, 17'h1_0002);
    drain();

    // Streaming: back-to-back inputs must emerge on consecutive cycles.
    base = out_cnt;
    out_rd = 1'b1;
    for (int i = 0; i < 8; i++) send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    drain();
    check("stream_count", 32'(out_cnt - base), 32'(8));
    check("stream_consec", 32'(run), 32'(8));

    // Backpressure: fill with the consumer stalled.
    out_rd = 1'b0; acc = 0; have = 1'b0; snap = '0;
    for (int i = 0; i < 6; i++) begin
      a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom); sub = 1'b0; in_vld = 1'b1;
      @(negedge clk);
      if (in_rd) acc++;
      if (out_vld) begin
        if (!have) begin
          snap = {co, s};
          have = 1'b1;
        end else begin
          check("bp_stable", 32'({co, s}), 32'(snap));
        end
      end
      @(posedge clk); #1;
    end
    check("bp_accepts", 32'(acc), 32'(4));
    check("bp_in_rd", 32'(in_rd), 32'(0));
    check("bp_hold", 32'({out_vld, co, s}), 32'({1'b1, snap}));
    in_vld = 1'b0;
    base = out_cnt;
    out_rd = 1'b1;
    drain();
    check("bp_count", 32'(out_cnt - base), 32'(4));
    check("bp_consec", 32'(run), 32'(4));

    // Reset with three results in flight.
    out_rd = 1'b0;
    for (int i = 0; i < 3; i++) send(16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
    @(posedge clk); #1;
    check("pre_rst_vld", 32'(out_vld), 32'(1));
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_out_vld", 32'(out_vld), 32'(0));
    check("mid_rst_s_co", 32'({co, s}), 32'(0));
    check("mid_rst_in_rd", 32'(in_rd), 32'(1));
    @(posedge clk); #3 rst_n = 1'b1;
    out_rd = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_vld) n++;
    end
    check("no_stale", 32'(n), 32'(0));
    send(16'h8000, 16'h8000, 1'b1, 1'b0);
    wait_result(lat);
    check("post_rst_lat", 32'(lat), 32'(4));
    check("post_rst_val", 32'({co, s}), 32'(17'h1_0001));
    drain();

    // Random traffic with random stalls on both sides.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      acc = (in_vld && in_rd) ? 1 : 0;
      @(posedge clk); #1;
      if (!in_vld || acc == 1) begin
        in_vld = ($urandom_range(0, 3) != 0);
        a   = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
        b   = ($urandom_range(0, 7) == 0) ? 16'h0001 : 16'($urandom);
        ci  = 1'($urandom);
        sub = 1'($urandom);
      end
      out_rd = ($urandom_range(0, 3) != 0);
    end
    in_vld = 1'b0;
    out_rd = 1'b1;
    drain();
    check("rand_outputs", 32'(out_cnt > 100), 32'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
